byte_lane_mem: RTL and testbench
================================

BYTE_LANE_MEM -- requirements
Module: byte_lane_mem

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the byte-address width; memory depth is 2^ADDR_W bytes.
REQ-002 The block SHALL have parameter LANES, default 2, meaning bytes per write word; LANES is a power of 2 and at least 1. LB = log2(LANES) and WA_W = ADDR_W-LB.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have write port 1 signals: we1 (input, 1 bit, write enable); wa1 (input, WA_W bits, word address); be1 (input, LANES bits, byte-lane enables); wd1 (input, 8*LANES bits, data, lane k in bits [8k+7:8k]).
REQ-006 The block SHALL have write port 2 signals: we2, wa2, be2 and wd2, with the same widths and meanings as port 1.
REQ-007 The block SHALL have read-port signals: rd_req (input, 1 bit); ra (input, ADDR_W bits, byte address); rd_valid (output, 1 bit); rd (output, 8 bits).
REQ-008 The block SHALL have status outputs: busy (1 bit, clear in progress); conflict (1 bit); conflict_cnt (8 bits).

Function
REQ-009 The block SHALL use a two-state FSM, CLEAR and RUN, where CLEAR writes 0x00 to every lane of word clr_idx, one word per cycle, starting at clr_idx = 0.
REQ-010 On the edge where clr_idx = 2^WA_W-1, the FSM SHALL move CLEAR->RUN, so CLEAR lasts exactly 2^WA_W cycles after rst_n deasserts; busy=1 in CLEAR and 0 in RUN.
REQ-011 In CLEAR, the block SHALL ignore we1, we2 and rd_req: no memory update from either port, rd_valid=0, and conflict and conflict_cnt unchanged.
REQ-012 In RUN with we1=1, the block SHALL write wd1 lane k to byte mem[{wa1,k}] for each lane k where be1[k]=1, and leave lanes with be1[k]=0 unchanged.
REQ-013 In RUN with we1=0 and we2=1, the block SHALL perform the same lane-wise write from port 2 (we2, wa2, be2, wd2).
REQ-014 In RUN with we1=0 and we2=0, the block SHALL perform no write.
REQ-015 In RUN with we1=1 and we2=1, port 1 SHALL win and port 2 SHALL be dropped entirely, even for disjoint addresses or lanes.
REQ-016 On a we1=1, we2=1 cycle in RUN, the block SHALL set conflict=1 for exactly the next cycle (registered pulse) and increment conflict_cnt by 1, saturating at 0xFF.
REQ-017 A write with we=1 and all be bits 0 SHALL be a no-op, but still counts as an active port for the REQ-015 and REQ-016 priority and conflict rules.
REQ-018 Reads SHALL have one-cycle latency: rd_req=1 in RUN at edge N gives rd_valid=1 and rd=mem[ra] during cycle N+1; otherwise rd_valid=0 and rd holds its last value.
REQ-019 Reads SHALL be read-first: if a write to ra's byte occurs at the same edge as the read, rd returns the pre-write byte.
REQ-020 Back-to-back rd_req SHALL be accepted every cycle with no bubbles.
REQ-021 The block SHALL generalise the byte-lane write so that LANES=1 degenerates to plain byte writes with WA_W = ADDR_W.

Reset
REQ-022 While rst_n=0, the block SHALL hold: FSM=CLEAR, clr_idx=0, busy=1, rd_valid=0, rd=0x00, conflict=0, conflict_cnt=0x00.
REQ-023 Memory contents SHALL be altered only by the CLEAR sequence, never by the asynchronous reset itself.
REQ-024 Reset asserted mid-CLEAR or mid-RUN SHALL abort the current activity, and clearing SHALL restart from word 0 after release.
REQ-025 A read or write in flight at reset assertion SHALL be discarded, and rd_valid SHALL not assert for it.

Verification
REQ-026 The bench SHALL check clear timing: with defaults, release rst_n -> busy=1 for exactly 128 cycles; after busy falls, a read of every address 0x00..0xFF returns 0x00 with rd_valid one cycle after each rd_req.
REQ-027 The bench SHALL check lane write: we1=1, wa1=0x05, be1=2'b10, wd1=0xBEEF -> reading 0x0B returns 0xBE and reading 0x0A returns 0x00.
REQ-028 The bench SHALL check priority: we1=1 wa1=0x10 wd1=0x1111 be1=11 together with we2=1 wa2=0x20 wd2=0x2222 be2=11 in one cycle -> 0x20 and 0x21 hold 0x11, 0x40 and 0x41 stay 0x00, conflict=1 for one cycle, conflict_cnt=1.
REQ-029 The bench SHALL check conflict saturation: 300 consecutive dual-write cycles -> conflict_cnt=0xFF and conflict stays high throughout.
REQ-030 The bench SHALL check read-first: mem[0x06]=0x00; rd_req=1 ra=0x06 together with we2=1 wa2=0x03 be2=01 wd2=0x00AA -> rd_valid=1 with rd=0x00; the next read of 0x06 returns 0xAA.
REQ-031 The bench SHALL check reset mid-clear: assert rst_n=0 at cycle 50 of CLEAR, release -> busy=1 for a full 128 cycles again, rd_valid=0 throughout, and rd_req during busy produces no rd_valid.

Source files
------------

// File: rtl/byte_lane_mem_if.sv
// Bus bundle for byte_lane_mem: two byte-lane write ports, one byte read port
// and the clear/conflict status lines.
interface byte_lane_mem_if #(
    parameter int ADDR_W = 8,
    parameter int LANES  = 2
);
    localparam int LB   = $clog2(LANES);
    localparam int WA_W = ADDR_W - LB;

    logic                 we1;
    logic [WA_W-1:0]      wa1;
    logic [LANES-1:0]     be1;
    logic [8*LANES-1:0]   wd1;
    logic                 we2;
    logic [WA_W-1:0]      wa2;
    logic [LANES-1:0]     be2;
    logic [8*LANES-1:0]   wd2;
    logic                 rd_req;
    logic [ADDR_W-1:0]    ra;
    logic                 rd_valid;
    logic [7:0]           rd;
    logic                 busy;
    logic                 conflict;
    logic [7:0]           conflict_cnt;

    modport master (
        output we1, wa1, be1, wd1,
        output we2, wa2, be2, wd2,
        output rd_req, ra,
        input  rd_valid, rd, busy, conflict, conflict_cnt
    );

    modport slave (
        input  we1, wa1, be1, wd1,
        input  we2, wa2, be2, wd2,
        input  rd_req, ra,
        output rd_valid, rd, busy, conflict, conflict_cnt
    );
endinterface

// File: rtl/byte_lane_mem.sv
// Byte-addressable memory with two prioritised byte-lane write ports, a
// one-cycle read-first byte read port and a self-clearing start-up sequence.
module byte_lane_mem #(
    parameter int ADDR_W = 8,
    parameter int LANES  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    byte_lane_mem_if.slave  bus
);
    localparam int LB    = $clog2(LANES);
    localparam int WA_W  = ADDR_W - LB;
    localparam int DEPTH = 1 << WA_W;
    localparam int LBW   = (LB > 0) ? LB : 1;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t               r_state;
    logic [WA_W-1:0]      r_clr_idx;
    logic                 r_busy;
    logic                 r_conflict;
    logic [7:0]           r_conflict_cnt;
    logic                 r_rd_valid;
    logic [LBW-1:0]       r_rd_lane;
    logic [7:0]           r_rd_hold;

    logic                 w_run;
    logic [WA_W-1:0]      w_wr_addr;
    logic [LANES-1:0]     w_wr_be;
    logic [8*LANES-1:0]   w_wr_data;
    logic [LANES-1:0]     w_lane_we;
    logic [WA_W-1:0]      w_rd_word;
    logic [LBW-1:0]       w_rd_lane;
    logic                 w_rd_acc;
    logic [8*LANES-1:0]   w_lane_q;
    logic [7:0]           w_rd_sel;

    assign w_run    = (r_state == S_RUN);
    assign w_rd_acc = w_run & bus.rd_req;

    // CLEAR owns the write path; in RUN port 1 beats port 2 outright.
    always_comb begin
        w_wr_addr = r_clr_idx;
        w_wr_be   = '1;
        w_wr_data = '0;
        if (w_run) begin
            if (bus.we1) begin
                w_wr_addr = bus.wa1;
                w_wr_be   = bus.be1;
                w_wr_data = bus.wd1;
            end else if (bus.we2) begin
                w_wr_addr = bus.wa2;
                w_wr_be   = bus.be2;
                w_wr_data = bus.wd2;
            end else begin
                w_wr_addr = bus.wa1;
                w_wr_be   = '0;
                w_wr_data = bus.wd1;
            end
        end
    end

    // Gating with rst_n keeps a held reset from repeatedly rewriting word 0.
    assign w_lane_we = {LANES{rst_n}} & (w_run ? w_wr_be : {LANES{1'b1}});

    generate
        if (LB == 0) begin : g_byte_addr
            assign w_rd_word = bus.ra;
            assign w_rd_lane = '0;
        end else begin : g_lane_addr
            assign w_rd_word = bus.ra[ADDR_W-1:LB];
            assign w_rd_lane = bus.ra[LB-1:0];
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] r_q;

            // Non-blocking read alongside the write gives read-first behaviour.
            always_ff @(posedge clk) begin
                if (w_lane_we[gi]) begin
                    mem[w_wr_addr] <= w_wr_data[8*gi +: 8];
                end
                if (w_rd_acc) begin
                    r_q <= mem[w_rd_word];
                end
            end

            assign w_lane_q[8*gi +: 8] = r_q;
        end
    endgenerate

    assign w_rd_sel = w_lane_q[{r_rd_lane, 3'b000} +: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (&r_clr_idx) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_state <= S_RUN;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict     <= 1'b0;
            r_conflict_cnt <= '0;
        end else if (w_run) begin
            r_conflict <= bus.we1 & bus.we2;
            if (bus.we1 && bus.we2 && r_conflict_cnt != 8'hFF) begin
                r_conflict_cnt <= r_conflict_cnt + 8'd1;
            end
        end
    end

    // rd shows fresh RAM data for one cycle, then the captured copy holds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_lane  <= '0;
            r_rd_hold  <= '0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_lane <= w_rd_lane;
            end
            if (r_rd_valid) begin
                r_rd_hold <= w_rd_sel;
            end
        end
    end

    assign bus.rd           = r_rd_valid ? w_rd_sel : r_rd_hold;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.busy         = r_busy;
    assign bus.conflict     = r_conflict;
    assign bus.conflict_cnt = r_conflict_cnt;
endmodule

// File: tb/tb_byte_lane_mem.sv
// Directed plus randomized bench for byte_lane_mem against a flat byte-array
// reference model with port-priority and saturating-counter rules.
module tb_byte_lane_mem;
    logic clk;
    logic rst_n;

    byte_lane_mem_if #(.ADDR_W(8), .LANES(2)) bus ();

    byte_lane_mem #(.ADDR_W(8), .LANES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ref_mem [256];
    logic [7:0] exp_rd;
    int         exp_cnt;
    int         n_vec;
    int         n_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input logic [6:0] a, input logic [1:0] b, input logic [15:0] d);
        for (int k = 0; k < 2; k++) begin
            if (b[k]) ref_mem[a * 2 + k] = d[8*k +: 8];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        exp_rd  = 8'h00;
        exp_cnt = 0;
    endtask

    // One RUN-mode cycle: drive, predict from the model, clock, compare.
    task automatic cycle(input logic w1, input logic [6:0] a1, input logic [1:0] b1,
                         input logic [15:0] d1, input logic w2, input logic [6:0] a2,
                         input logic [1:0] b2, input logic [15:0] d2,
                         input logic rq, input logic [7:0] a);
        bus.we1 = w1; bus.wa1 = a1; bus.be1 = b1; bus.wd1 = d1;
        bus.we2 = w2; bus.wa2 = a2; bus.be2 = b2; bus.wd2 = d2;
        bus.rd_req = rq; bus.ra = a;
        if (rq) exp_rd = ref_mem[a];
        if (w1) model_write(a1, b1, d1);
        else if (w2) model_write(a2, b2, d2);
        if (w1 && w2 && exp_cnt < 255) exp_cnt++;
        tick();
        check("rd_valid", {31'd0, bus.rd_valid}, {31'd0, rq});
        check("rd", {24'd0, bus.rd}, {24'd0, exp_rd});
        check("conflict", {31'd0, bus.conflict}, {31'd0, (w1 & w2)});
        check("conflict_cnt", {24'd0, bus.conflict_cnt}, exp_cnt);
    endtask

    task automatic idle();
        cycle(1'b0, 7'd0, 2'b00, 16'h0, 1'b0, 7'd0, 2'b00, 16'h0, 1'b0, 8'h00);
    endtask

    task automatic rd_byte(input logic [7:0] a);
        cycle(1'b0, 7'd0, 2'b00, 16'h0, 1'b0, 7'd0, 2'b00, 16'h0, 1'b1, a);
    endtask

    initial begin
        int n;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.we1 = 0; bus.wa1 = 0; bus.be1 = 0; bus.wd1 = 0;
        bus.we2 = 0; bus.wa2 = 0; bus.be2 = 0; bus.wd2 = 0;
        bus.rd_req = 0; bus.ra = 0;
        model_reset();

        // Reset state.
        tick(); tick();
        check("rst_busy", {31'd0, bus.busy}, 32'd1);
        check("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        check("rst_rd", {24'd0, bus.rd}, 32'd0);
        check("rst_conflict", {31'd0, bus.conflict}, 32'd0);
        check("rst_cnt", {24'd0, bus.conflict_cnt}, 32'd0);

        // Clear timing, with rd_req held to show reads are ignored meanwhile.
        rst_n = 1'b1;
        bus.rd_req = 1'b1;
        n = 0;
        while (bus.busy && n < 1000) begin
            tick();
            n++;
            check("clr_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        end
        check("clear_cycles", n, 32'd128);
        bus.rd_req = 1'b0;

        for (int a = 0; a < 256; a++) rd_byte(8'(a));
        idle();
        check("rd_hold", {24'd0, bus.rd}, 32'd0);

        // Lane write on the upper lane only.
        cycle(1'b1, 7'h05, 2'b10, 16'hBEEF, 1'b0, 7'd0, 2'b00, 16'h0, 1'b0, 8'h00);
        rd_byte(8'h0B);
        check("lane_hi", {24'd0, bus.rd}, 32'hBE);
        rd_byte(8'h0A);
        check("lane_lo", {24'd0, bus.rd}, 32'h00);

        // Dual write: port 1 wins, port 2 dropped.
        cycle(1'b1, 7'h10, 2'b11, 16'h1111, 1'b1, 7'h20, 2'b11, 16'h2222, 1'b0, 8'h00);
        check("prio_conflict", {31'd0, bus.conflict}, 32'd1);
        idle();
        check("prio_conflict_fall", {31'd0, bus.conflict}, 32'd0);
        check("prio_cnt", {24'd0, bus.conflict_cnt}, 32'd1);
        rd_byte(8'h20); check("prio_20", {24'd0, bus.rd}, 32'h11);
        rd_byte(8'h21); check("prio_21", {24'd0, bus.rd}, 32'h11);
        rd_byte(8'h40); check("prio_40", {24'd0, bus.rd}, 32'h00);
        rd_byte(8'h41); check("prio_41", {24'd0, bus.rd}, 32'h00);

        // Read-first on a same-edge write.
        rd_byte(8'h06);
        cycle(1'b0, 7'd0, 2'b00, 16'h0, 1'b1, 7'h03, 2'b01, 16'h00AA, 1'b1, 8'h06);
        check("rf_old", {24'd0, bus.rd}, 32'h00);
        rd_byte(8'h06);
        check("rf_new", {24'd0, bus.rd}, 32'hAA);

        // Zero-lane writes still arbitrate and count as a conflict.
        cycle(1'b1, 7'h30, 2'b00, 16'h5555, 1'b1, 7'h31, 2'b11, 16'h6666, 1'b0, 8'h00);
        rd_byte(8'h62); check("be0_p2_drop", {24'd0, bus.rd}, 32'h00);

        // Conflict counter saturation.
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 7'($urandom_range(0, 127)), 2'($urandom), 16'($urandom),
                  1'b1, 7'($urandom_range(0, 127)), 2'($urandom), 16'($urandom),
                  1'b0, 8'h00);
        end
        check("sat_cnt", {24'd0, bus.conflict_cnt}, 32'hFF);
        idle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 2) == 0), 7'($urandom), 2'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 7'($urandom), 2'($urandom), 16'($urandom),
                  1'($urandom_range(0, 3) != 0), 8'($urandom));
        end

        // Reset with a read in flight: no rd_valid for it.
        bus.we1 = 0; bus.we2 = 0;
        bus.rd_req = 1'b1; bus.ra = 8'h0B;
        #2 rst_n = 1'b0;
        tick();
        check("inflight_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        check("inflight_rd", {24'd0, bus.rd}, 32'd0);
        check("inflight_cnt", {24'd0, bus.conflict_cnt}, 32'd0);
        check("inflight_busy", {31'd0, bus.busy}, 32'd1);

        // Reset at cycle 50 of CLEAR, then a full clear again.
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            bus.ra = 8'($urandom);
            tick();
            check("mid_busy", {31'd0, bus.busy}, 32'd1);
            check("mid_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        end
        rst_n = 1'b0;
        tick();
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b1;
        n = 0;
        while (bus.busy && n < 1000) begin
            bus.ra = 8'($urandom);
            tick();
            n++;
            check("reclr_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        end
        check("reclear_cycles", n, 32'd128);
        bus.rd_req = 1'b0;
        model_reset();
        rd_byte(8'h0B); check("reclr_0B", {24'd0, bus.rd}, 32'h00);
        rd_byte(8'h06); check("reclr_06", {24'd0, bus.rd}, 32'h00);
        for (int i = 0; i < 32; i++) rd_byte(8'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
